// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: queues host commands and issues them one at a time to an LCD
// controller, waiting for each handshake under a response watchdog.
module lcd_cmd_seq #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [2:0] push_cmd,
    output logic       full,
    output logic       empty,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       busy,
    input  logic       done,
    output logic       seq_done,
    output logic       err,
    output logic [7:0] issued_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, WAIT_DONE, FIN, ERR} state_t;

    state_t        state_q, state_d;
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic [2:0]    cmd_q, cmd_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          seq_done_q, seq_done_d, err_q, err_d;
    logic          seen_q, seen_d;
    logic [7:0]    issued_q, issued_d, wd_q, wd_d;
    logic          pop, push_ok, wd_expired;

    always_comb begin
        pop        = state_q == IDLE && !empty_q && !busy;
        push_ok    = push && state_q != FIN && state_q != ERR && (!full_q || pop);
        wptr_d     = push_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
        count_d    = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
        full_d     = count_d == FULL_CNT;
        empty_d    = count_d == '0;
        wd_expired = wd_q == WD_LAST;
        state_d    = state_q;
        cmd_d      = cmd_q;
        cmd_valid_d = 1'b0;
        seq_done_d = seq_done_q;
        err_d      = err_q;
        issued_d   = issued_q;
        wd_d       = wd_q;
        seen_d     = seen_q;
        case (state_q)
            INIT: state_d = busy ? INIT : IDLE;
            IDLE: if (pop) begin
                state_d     = ISSUE;
                cmd_d       = mem_q[rptr_q];
                cmd_valid_d = 1'b1;
                issued_d    = issued_q == 8'hff ? issued_q : issued_q + 8'd1;
            end
            ISSUE: begin
                state_d = cmd_q == 3'b000 ? WAIT_DONE : WAIT;
                wd_d    = '0;
                seen_d  = 1'b0;
            end
            // busy must be seen high before a low level counts as completion
            WAIT: begin
                wd_d   = wd_q + 8'd1;
                seen_d = seen_q | busy;
                if (seen_q && !busy) state_d = IDLE;
                else if (wd_expired) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            WAIT_DONE: begin
                wd_d = wd_q + 8'd1;
                if (done) begin
                    state_d    = FIN;
                    seq_done_d = 1'b1;
                end else if (wd_expired) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= INIT;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            cmd_q       <= 3'b000;
            cmd_valid_q <= 1'b0;
            seq_done_q  <= 1'b0;
            err_q       <= 1'b0;
            issued_q    <= '0;
            wd_q        <= '0;
            seen_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            seq_done_q  <= seq_done_d;
            err_q       <= err_d;
            issued_q    <= issued_d;
            wd_q        <= wd_d;
            seen_q      <= seen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= push_cmd;
    end

    assign full       = full_q;
    assign empty      = empty_q;
    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign seq_done   = seq_done_q;
    assign err        = err_q;
    assign issued_cnt = issued_q;
endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb_lcd_cmd_seq: directed scenarios for lcd_cmd_seq with hand-computed expectations.
module tb_lcd_cmd_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic [2:0] push_cmd = 3'b000;
    logic       busy = 1'b1;
    logic       done = 1'b0;
    logic       full, empty, cmd_valid, seq_done, err;
    logic [2:0] cmd;
    logic [7:0] issued_cnt;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    logic [2:0] got [$];
    logic [2:0] c41 [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
    logic [2:0] c42 [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};

    lcd_cmd_seq #(.DEPTH(8), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .push(push), .push_cmd(push_cmd),
        .full(full), .empty(empty), .cmd(cmd), .cmd_valid(cmd_valid),
        .busy(busy), .done(done), .seq_done(seq_done), .err(err),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_valid === 1'b1) pulses++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation ran past 500000 time units, want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic b);
        reset = 1'b0;
        busy = b;
        push = 1'b0;
        done = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++)
            if (cmd_valid === 1'b1) ok = 1'b1;
            else tick();
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL wait_valid: cmd_valid stayed 0 for 300 cycles, want 1");
        end
    endtask

    // plays the LCD controller for n commands: busy pulse for moves, done for Write
    task automatic serve(input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_valid(ok);
            if (!ok) break;
            got.push_back(cmd);
            if (cmd != 3'b000) begin
                busy = 1'b1;
                tick();
                tick();
                busy = 1'b0;
                tick();
            end else begin
                tick();
                done = 1'b1;
                tick();
                done = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks += 7;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        if (cmd !== 3'b000) begin errors++; $display("FAIL reset_cmd: got %b want 000", cmd); end
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
        if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_seq_done: got %b want 0", seq_done); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        if (issued_cnt !== 8'd0) begin errors++; $display("FAIL reset_issued: got %0d want 0", issued_cnt); end
    endtask

    task automatic test_init_hold();
        int p0;
        logic [2:0] exp [3] = '{3'b011, 3'b101, 3'b000};
        do_reset(1'b1);
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1;
            push_cmd = exp[i];
            tick();
        end
        push = 1'b0;
        repeat (127) tick();
        checks += 2;
        if (pulses != p0) begin errors++; $display("FAIL init_no_issue: got %0d pulses want 0", pulses - p0); end
        if (empty !== 1'b0) begin errors++; $display("FAIL init_queued: empty got %b want 0", empty); end
        busy = 1'b0;
        got.delete();
        serve(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL init_order[%0d]: got %b want %b", i, got[i], exp[i]); end
        end
        checks += 4;
        if (seq_done !== 1'b1) begin errors++; $display("FAIL init_seq_done: got %b want 1", seq_done); end
        if (issued_cnt !== 8'd3) begin errors++; $display("FAIL init_issued: got %0d want 3", issued_cnt); end
        if (pulses - p0 != 3) begin errors++; $display("FAIL init_pulses: got %0d want 3", pulses - p0); end
        if (err !== 1'b0) begin errors++; $display("FAIL init_err: got %b want 0", err); end
    endtask

    task automatic test_overflow();
        int p0;
        do_reset(1'b1);
        p0 = pulses;
        for (int i = 0; i < 9; i++) begin
            push = 1'b1;
            push_cmd = c41[i];
            tick();
            if (i == 6) begin
                checks++;
                if (full !== 1'b0) begin errors++; $display("FAIL ovf_full_at7: got %b want 0", full); end
            end
            if (i == 7) begin
                checks++;
                if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_at8: got %b want 1", full); end
            end
        end
        push = 1'b0;
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_at9: got %b want 1", full); end
        busy = 1'b0;
        got.delete();
        serve(8);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== c41[i]) begin errors++; $display("FAIL ovf_order[%0d]: got %b want %b", i, got[i], c41[i]); end
        end
        repeat (20) tick();
        checks += 3;
        if (pulses - p0 != 8) begin errors++; $display("FAIL ovf_pulses: got %0d want 8", pulses - p0); end
        if (issued_cnt !== 8'd8) begin errors++; $display("FAIL ovf_issued: got %0d want 8", issued_cnt); end
        if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b want 1", empty); end
    endtask

    task automatic test_full_push_pop();
        int p0;
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            push = 1'b1;
            push_cmd = c42[i];
            tick();
        end
        push = 1'b0;
        busy = 1'b0;
        tick();
        busy = 1'b1;
        p0 = pulses;
        tick();
        tick();
        checks += 2;
        if (full !== 1'b1) begin errors++; $display("FAIL fpp_full_idle: got %b want 1", full); end
        if (pulses != p0) begin errors++; $display("FAIL fpp_hold_idle: got %0d pulses want 0", pulses - p0); end
        busy = 1'b0;
        push = 1'b1;
        push_cmd = 3'b000;
        tick();
        push = 1'b0;
        checks += 4;
        if (cmd_valid !== 1'b1) begin errors++; $display("FAIL fpp_issue: cmd_valid got %b want 1", cmd_valid); end
        if (cmd !== 3'd1) begin errors++; $display("FAIL fpp_cmd: got %b want 001", cmd); end
        if (full !== 1'b1) begin errors++; $display("FAIL fpp_full_kept: got %b want 1", full); end
        if (empty !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b want 0", empty); end
        got.delete();
        serve(9);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== c42[i]) begin errors++; $display("FAIL fpp_order[%0d]: got %b want %b", i, got[i], c42[i]); end
        end
        checks += 3;
        if (got[8] !== 3'b000) begin errors++; $display("FAIL fpp_pushed_cmd: got %b want 000", got[8]); end
        if (seq_done !== 1'b1) begin errors++; $display("FAIL fpp_seq_done: got %b want 1", seq_done); end
        if (issued_cnt !== 8'd9) begin errors++; $display("FAIL fpp_issued: got %0d want 9", issued_cnt); end
    endtask

    task automatic test_timeout();
        bit ok;
        int p0;
        do_reset(1'b0);
        tick();
        tick();
        push = 1'b1;
        push_cmd = 3'b001;
        tick();
        push = 1'b0;
        wait_valid(ok);
        busy = 1'b1;
        repeat (255) tick();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL to_early: err got %b want 0", err); end
        tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err); end
        p0 = pulses;
        busy = 1'b0;
        push = 1'b1;
        push_cmd = 3'b010;
        repeat (3) tick();
        push = 1'b0;
        repeat (10) tick();
        checks += 4;
        if (pulses != p0) begin errors++; $display("FAIL to_no_issue: got %0d pulses want 0", pulses - p0); end
        if (empty !== 1'b1) begin errors++; $display("FAIL to_push_ignored: empty got %b want 1", empty); end
        if (err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", err); end
        if (issued_cnt !== 8'd1) begin errors++; $display("FAIL to_issued: got %0d want 1", issued_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int p0;
        logic [2:0] q [5] = '{3'b101, 3'b000, 3'b010, 3'b011, 3'b100};
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            push = 1'b1;
            push_cmd = q[i];
            tick();
        end
        push = 1'b0;
        busy = 1'b0;
        got.delete();
        serve(1);
        wait_valid(ok);
        tick();
        tick();
        tick();
        checks += 3;
        if (empty !== 1'b0) begin errors++; $display("FAIL rm_queued: empty got %b want 0", empty); end
        if (issued_cnt !== 8'd2) begin errors++; $display("FAIL rm_issued_pre: got %0d want 2", issued_cnt); end
        if (seq_done !== 1'b0) begin errors++; $display("FAIL rm_waiting: seq_done got %b want 0", seq_done); end
        #2;
        reset = 1'b0;
        #1;
        checks += 7;
        if (empty !== 1'b1) begin errors++; $display("FAIL rm_empty: got %b want 1", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL rm_full: got %b want 0", full); end
        if (cmd !== 3'b000) begin errors++; $display("FAIL rm_cmd: got %b want 000", cmd); end
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rm_cmd_valid: got %b want 0", cmd_valid); end
        if (seq_done !== 1'b0) begin errors++; $display("FAIL rm_seq_done: got %b want 0", seq_done); end
        if (err !== 1'b0) begin errors++; $display("FAIL rm_err: got %b want 0", err); end
        if (issued_cnt !== 8'd0) begin errors++; $display("FAIL rm_issued: got %0d want 0", issued_cnt); end
        busy = 1'b1;
        tick();
        reset = 1'b1;
        p0 = pulses;
        repeat (5) tick();
        busy = 1'b0;
        repeat (10) tick();
        checks += 2;
        if (empty !== 1'b1) begin errors++; $display("FAIL rm_discarded: empty got %b want 1", empty); end
        if (pulses != p0) begin errors++; $display("FAIL rm_no_issue: got %0d pulses want 0", pulses - p0); end
        push = 1'b1;
        push_cmd = 3'b110;
        tick();
        push = 1'b0;
        wait_valid(ok);
        checks++;
        if (cmd !== 3'b110) begin errors++; $display("FAIL rm_restart_cmd: got %b want 110", cmd); end
    endtask

    task automatic test_write_stops();
        int p0;
        do_reset(1'b0);
        tick();
        tick();
        push = 1'b1;
        push_cmd = 3'b000;
        tick();
        push_cmd = 3'b001;
        tick();
        push = 1'b0;
        got.delete();
        serve(1);
        p0 = pulses;
        checks += 2;
        if (got[0] !== 3'b000) begin errors++; $display("FAIL ws_first: got %b want 000", got[0]); end
        if (seq_done !== 1'b1) begin errors++; $display("FAIL ws_seq_done: got %b want 1", seq_done); end
        push = 1'b1;
        push_cmd = 3'b011;
        tick();
        push = 1'b0;
        repeat (20) tick();
        checks += 4;
        if (pulses != p0) begin errors++; $display("FAIL ws_no_issue: got %0d pulses want 0", pulses - p0); end
        if (issued_cnt !== 8'd1) begin errors++; $display("FAIL ws_issued: got %0d want 1", issued_cnt); end
        if (empty !== 1'b0) begin errors++; $display("FAIL ws_left_queued: empty got %b want 0", empty); end
        if (cmd !== 3'b000) begin errors++; $display("FAIL ws_cmd_hold: got %b want 000", cmd); end
    endtask

    initial begin
        test_reset();
        test_init_hold();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_reset_mid();
        test_write_stops();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
